latch_exerciser: RTL and testbench

Synchronous stimulus/checker that drives a gated D-latch (D, enable, optional reset) and reads back its Q/Q_bar outputs to verify transparency and hold behaviour. It is the initiator side of the latch interface: it writes a pseudo-random bit per vector, waits for the gate-delay network to settle, and samples the latch outputs. It sits in the lab testbench/self-test path next to the gate-level latch instances, as the reusable driver for that interface.

---
 rtl/latch_ex_pkg.sv | 33 +++
 rtl/latch_exerciser_if.sv | 17 +
 rtl/latch_exerciser_sync2.sv | 21 ++
 rtl/latch_exerciser.sv | 194 +++++++++++++++++++
 tb/tb_latch_exerciser.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/latch_ex_pkg.sv
// Shared types and constants for the gated D-latch exerciser.
// Optional reset-check states are compiled in with LATCH_EX_RESET_EN.
package latch_ex_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_OPEN,
    ST_WAIT1,
    ST_CHECK_T,
    ST_CLOSE,
    ST_WAIT2,
    ST_FLIP,
    ST_WAIT3,
    ST_CHECK_H,
    ST_DONE
`ifdef LATCH_EX_RESET_EN
    ,
    ST_RST_ASSERT,
    ST_WAIT4,
    ST_CHECK_R,
    ST_RST_RELEASE
`endif
  } state_e;

  // x^8+x^6+x^5+x^4+1 as taps on bits 7,5,4,3 of a left-shifting register
  localparam logic [7:0] LFSR_TAPS = 8'hB8;
  localparam logic [7:0] ERR_SAT   = 8'd255;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/latch_exerciser_if.sv
// Latch-side bus: the exerciser (master) drives D/enable/reset, the latch (slave) returns Q/Q_bar.
// latch_rst exists only with LATCH_EX_RESET_EN.
interface latch_exerciser_if;
  logic latch_d;
  logic latch_clk;
  logic latch_q;
  logic latch_q_bar;
`ifdef LATCH_EX_RESET_EN
  logic latch_rst;

  modport master (output latch_d, latch_clk, latch_rst, input latch_q, latch_q_bar);
  modport slave  (input latch_d, latch_clk, latch_rst, output latch_q, latch_q_bar);
`else
  modport master (output latch_d, latch_clk, input latch_q, latch_q_bar);
  modport slave  (input latch_d, latch_clk, output latch_q, latch_q_bar);
`endif
endinterface

// File: rtl/latch_exerciser_sync2.sv
// Two-flop synchronizer for one asynchronous bit; two cycles latency, reset value 0.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/latch_exerciser.sv
// Drives a gated D-latch with LFSR vectors and checks transparency then hold on each vector.
// LATCH_EX_RESET_EN adds a latch reset port and a reset check before the first vector.
module latch_exerciser
  import latch_ex_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned NUM_VECTORS   = 16,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  latch_exerciser_if.master        lat,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [7:0]               err_count,
  output logic [7:0]               vec_count
);

  localparam logic [7:0] WAIT_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [8:0] NV        = 9'(NUM_VECTORS);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] err_q, err_d;
  logic [7:0] vec_q, vec_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ld_q, ld_d;
  logic       lc_q, lc_d;
`ifdef LATCH_EX_RESET_EN
  logic       lr_q, lr_d;
`endif
  logic       sq, sqb;
  logic       chk_fail;
  logic       b;
  logic       b_next;

  sync2 u_sync_q    (.clk(clk), .rst(rst), .d_i(lat.latch_q),     .q_o(sq));
  sync2 u_sync_qbar (.clk(clk), .rst(rst), .d_i(lat.latch_q_bar), .q_o(sqb));

  assign b = lfsr_q[0];

  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    lfsr_d   = lfsr_q;
    err_d    = err_q;
    vec_d    = vec_q;
    pass_d   = pass_q;
    chk_fail = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d  = '0;
          vec_d  = '0;
          pass_d = 1'b0;
          lfsr_d = LFSR_SEED;
`ifdef LATCH_EX_RESET_EN
          state_d = ST_RST_ASSERT;
`else
          state_d = ST_OPEN;
`endif
        end
      end
`ifdef LATCH_EX_RESET_EN
      ST_RST_ASSERT: state_d = ST_WAIT4;
      ST_WAIT4: begin
        if (wait_q == WAIT_LAST) state_d = ST_CHECK_R;
        else                     wait_d  = wait_q + 8'd1;
      end
      ST_CHECK_R: begin
        chk_fail = (sq != 1'b0) || (sqb != 1'b1);
        state_d  = ST_RST_RELEASE;
      end
      ST_RST_RELEASE: state_d = ST_OPEN;
`endif
      ST_OPEN: state_d = ST_WAIT1;
      ST_WAIT1: begin
        if (wait_q == WAIT_LAST) state_d = ST_CHECK_T;
        else                     wait_d  = wait_q + 8'd1;
      end
      ST_CHECK_T: begin
        chk_fail = (sq != b) || (sqb == sq);
        state_d  = ST_CLOSE;
      end
      ST_CLOSE: state_d = ST_WAIT2;
      ST_WAIT2: begin
        if (wait_q == WAIT_LAST) state_d = ST_FLIP;
        else                     wait_d  = wait_q + 8'd1;
      end
      ST_FLIP: state_d = ST_WAIT3;
      ST_WAIT3: begin
        if (wait_q == WAIT_LAST) state_d = ST_CHECK_H;
        else                     wait_d  = wait_q + 8'd1;
      end
      ST_CHECK_H: begin
        chk_fail = (sq != b) || (sqb == sq);
        vec_d    = vec_q + 8'd1;
        lfsr_d   = lfsr_step(lfsr_q);
        state_d  = (({1'b0, vec_q} + 9'd1) < NV) ? ST_OPEN : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (chk_fail && (err_q != ERR_SAT)) err_d = err_q + 8'd1;
    // pass must already be valid in the cycle done is high
    if (state_d == ST_DONE) pass_d = (err_d == 8'd0);
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  assign b_next = lfsr_d[0];

  always_comb begin
    busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
    ld_d   = 1'b0;
    lc_d   = 1'b0;
`ifdef LATCH_EX_RESET_EN
    lr_d   = 1'b0;
`endif
    unique case (state_d)
      ST_OPEN, ST_WAIT1, ST_CHECK_T: begin
        lc_d = 1'b1;
        ld_d = b_next;
      end
      ST_CLOSE, ST_WAIT2:           ld_d = b_next;
      ST_FLIP, ST_WAIT3, ST_CHECK_H: ld_d = ~b_next;
`ifdef LATCH_EX_RESET_EN
      ST_RST_ASSERT, ST_WAIT4, ST_CHECK_R: begin
        lc_d = 1'b1;
        ld_d = 1'b1;
        lr_d = 1'b1;
      end
      ST_RST_RELEASE: begin
        lc_d = 1'b1;
        ld_d = 1'b1;
      end
`endif
      default: begin
        ld_d = 1'b0;
        lc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      lfsr_q  <= LFSR_SEED;
      err_q   <= '0;
      vec_q   <= '0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ld_q    <= 1'b0;
      lc_q    <= 1'b0;
`ifdef LATCH_EX_RESET_EN
      lr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lfsr_q  <= lfsr_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ld_q    <= ld_d;
      lc_q    <= lc_d;
`ifdef LATCH_EX_RESET_EN
      lr_q    <= lr_d;
`endif
    end
  end

  assign lat.latch_d   = ld_q;
  assign lat.latch_clk = lc_q;
`ifdef LATCH_EX_RESET_EN
  assign lat.latch_rst = lr_q;
`endif
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_latch_exerciser.sv
// Bench for latch_exerciser: behavioural latch with injectable faults, randomized run order and reset point.
module tb_latch_exerciser;

  localparam int         SC      = 4;
  localparam int         NV      = 16;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         VEC_CYC = 5 + 3 * SC;
`ifdef LATCH_EX_RESET_EN
  localparam int         RUN_CYC = NV * VEC_CYC + 3 + SC;
`else
  localparam int         RUN_CYC = NV * VEC_CYC;
`endif

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, pass;
  logic [7:0] err_count, vec_count;

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0 ideal, 1 Q stuck at 0, 2 always transparent
  logic q_m  = 1'b0;
  logic lrst;

  latch_exerciser_if lif ();

  latch_exerciser #(
    .SETTLE_CYCLES(SC),
    .NUM_VECTORS  (NV),
    .LFSR_SEED    (SEED)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .lat      (lif),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_count(err_count),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

`ifdef LATCH_EX_RESET_EN
  assign lrst = lif.latch_rst;
`else
  assign lrst = 1'b0;
`endif

  always @(lif.latch_d, lif.latch_clk, lrst, mode) begin
    if (lrst)                               q_m = 1'b0;
    else if (mode == 1)                     q_m = 1'b0;
    else if (mode == 2 || lif.latch_clk)    q_m = lif.latch_d;
  end
  assign lif.latch_q     = q_m;
  assign lif.latch_q_bar = ~q_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected error total for a full run, from the vector bits the polynomial produces.
  function automatic int exp_errs(input int m);
    logic [7:0] s;
    int ones;
    int e;
    s = SEED;
    ones = 0;
    for (int i = 0; i < NV; i++) begin
      ones += int'(s[0]);
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    case (m)
      1:       e = 2 * ones;
      2:       e = NV;
      default: e = 0;
    endcase
    return (e > 255) ? 255 : e;
  endfunction

  task automatic run_check(input int m, input bit poke, input string tag);
    int n;
    int e;
    mode = m;
    e = exp_errs(m);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    chk({tag, "_busy_on"}, busy, 1);
    chk({tag, "_pass_clr"}, pass, 0);
    while (!done && n < RUN_CYC + 40) begin
      @(negedge clk);
      n++;
      start = poke && (n == 20);
    end
    start = 1'b0;
    chk({tag, "_done_cycle"}, n, RUN_CYC + 1);
    chk({tag, "_err"}, err_count, e);
    chk({tag, "_vec"}, vec_count, NV);
    chk({tag, "_pass"}, pass, (e == 0) ? 1 : 0);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_lclk_done"}, lif.latch_clk, 0);
    chk({tag, "_ld_done"}, lif.latch_d, 0);
    if (poke) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_one_pulse"}, done, 0);
    chk({tag, "_idle_after"}, busy, 0);
    chk({tag, "_pass_hold"}, pass, (e == 0) ? 1 : 0);
  endtask

  initial begin
    int gap;
    int pulses;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_count, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_ld", lif.latch_d, 0);
    chk("rst_lclk", lif.latch_clk, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    run_check(0, 1'b0, "ideal");
    run_check(1, 1'b0, "stuck0");
    run_check(2, 1'b0, "transp");
    run_check(0, 1'b1, "ignored_start");

    for (int r = 0; r < 3; r++) begin
      gap = $urandom_range(0, 6);
      repeat (gap) @(negedge clk);
      run_check(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand");
    end

    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5 * VEC_CYC + $urandom_range(0, VEC_CYC - 1)) @(negedge clk);
    chk("mid_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_err", err_count, 0);
    chk("mid_vec", vec_count, 0);
    chk("mid_ld", lif.latch_d, 0);
    chk("mid_lclk", lif.latch_clk, 0);
    pulses = 0;
    repeat (RUN_CYC + 20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mid_no_done", pulses, 0);
    run_check(0, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
